// File: rtl/shared_counter_arbiter.sv
// ----------------------------------------------------------------------------
// shared_counter_arbiter
//   Shares one CNT_WIDTH-bit up-counter between NUM_REQ requesters. A
//   round-robin arbiter picks one requester while idle. The counter then runs
//   from 0 up to that requester's terminal value, and a one-cycle done pulse
//   goes to it. If the owner drops its request while running, the run is
//   aborted and no done pulse is sent.
//
// Ports
//   clk       in   1                   clock, rising edge
//   reset     in   1                   asynchronous, active-high
//   req       in   NUM_REQ             level request per requester
//   req_term  in   NUM_REQ*CNT_WIDTH   terminal value, slice i = requester i
//   grant     out  NUM_REQ             one-hot owner of the counter, 0 when idle
//   done      out  NUM_REQ             one-cycle pulse to the finished requester
//   busy      out  1                   1 while the counter is running
//   count     out  CNT_WIDTH           current counter value
// ----------------------------------------------------------------------------
module shared_counter_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int CNT_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*CNT_WIDTH-1:0]   req_term,
    output logic [NUM_REQ-1:0]             grant,
    output logic [NUM_REQ-1:0]             done,
    output logic                           busy,
    output logic [CNT_WIDTH-1:0]           count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state_reg;
    logic [NUM_REQ-1:0]     grant_reg;
    logic [NUM_REQ-1:0]     done_reg;
    logic                   busy_reg;
    logic [CNT_WIDTH-1:0]   count_reg;
    logic [CNT_WIDTH-1:0]   term_reg;
    logic [IDX_W-1:0]       ptr_reg;

    logic [NUM_REQ-1:0]     eligible;
    logic                   found_next;
    logic [IDX_W-1:0]       winner_next;
    logic [NUM_REQ-1:0]     win_onehot;
    logic [IDX_W:0]         cand_sum;
    logic [IDX_W-1:0]       cand_idx;
    logic [CNT_WIDTH-1:0]   term_slice [NUM_REQ];

    // Unpack the flat terminal-value bus and build the one-hot winner vector.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign term_slice[gi] = req_term[gi*CNT_WIDTH +: CNT_WIDTH];
        assign win_onehot[gi] = (winner_next == IDX_W'(gi));
    end

    // A requester that is receiving done this cycle is not eligible, so a
    // request held through done cannot be re-granted immediately.
    assign eligible = req & ~done_reg;

    // Round-robin search: ptr+1, ptr+2, ... with wrap; the last winner is
    // checked last.
    always_comb begin
        found_next  = 1'b0;
        winner_next = ptr_reg;
        cand_sum    = '0;
        cand_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_sum = {1'b0, ptr_reg} + (IDX_W + 1)'(k);
            if (cand_sum >= NUM_REQ_W) begin
                cand_sum = cand_sum - NUM_REQ_W;
            end
            cand_idx = cand_sum[IDX_W-1:0];
            if (!found_next && eligible[cand_idx]) begin
                found_next  = 1'b1;
                winner_next = cand_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            done_reg  <= '0;
            busy_reg  <= 1'b0;
            count_reg <= '0;
            term_reg  <= '0;
            ptr_reg   <= IDX_W'(NUM_REQ - 1);
        end else begin
            done_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (found_next) begin
                        grant_reg <= win_onehot;
                        term_reg  <= term_slice[winner_next];
                        count_reg <= '0;
                        busy_reg  <= 1'b1;
                        ptr_reg   <= winner_next;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    // grant_reg is one-hot on the owner, so masking req with
                    // it tells whether the owner still requests. Abort wins
                    // over completion.
                    if ((req & grant_reg) == '0) begin
                        grant_reg <= '0;
                        count_reg <= '0;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else if (count_reg == term_reg) begin
                        done_reg  <= grant_reg;
                        grant_reg <= '0;
                        count_reg <= '0;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign grant = grant_reg;
    assign done  = done_reg;
    assign busy  = busy_reg;
    assign count = count_reg;

endmodule

// File: tb/tb_shared_counter_arbiter.sv
// ----------------------------------------------------------------------------
// tb_shared_counter_arbiter
//   Table-driven bench for shared_counter_arbiter. Each table row is one
//   clock cycle: inputs applied before the edge and outputs expected after it.
//   A row can first pulse reset. A hand-written sequence covers asynchronous
//   reset mid-run.
// ----------------------------------------------------------------------------
module tb_shared_counter_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] req_term = '0;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic        rst;
        logic [3:0]  req;
        logic [15:0] term;
        logic [3:0]  grant;
        logic [3:0]  done;
        logic        busy;
        logic [3:0]  count;
    } vec_t;

    vec_t vecs[$];

    shared_counter_arbiter #(.NUM_REQ(4), .CNT_WIDTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_term (req_term),
        .grant    (grant),
        .done     (done),
        .busy     (busy),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic add(input string nm, input logic r, input logic [3:0] rq,
                       input logic [15:0] tm, input logic [3:0] g,
                       input logic [3:0] d, input logic b, input logic [3:0] c);
        vec_t v;
        v.name = nm; v.rst = r; v.req = rq; v.term = tm;
        v.grant = g; v.done = d; v.busy = b; v.count = c;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [3:0] g, input logic [3:0] d,
                         input logic b, input logic [3:0] c);
        tests++;
        if (grant !== g || done !== d || busy !== b || count !== c) begin
            fails++;
            $display("FAIL %s: got grant=%b done=%b busy=%b count=%0d, expected grant=%b done=%b busy=%b count=%0d",
                     nm, grant, done, busy, count, g, d, b, c);
        end else begin
            $display("[TB] %s: grant=%b done=%b busy=%b count=%0d ok",
                     nm, grant, done, busy, count);
        end
    endtask

    task automatic do_reset();
        req      = '0;
        req_term = '0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        check("reset_state", 4'b0000, 4'b0000, 1'b0, 4'd0);
        reset = 1'b0;
    endtask

    initial begin
        // Test 1: requester 0, term 3.
        add("t1", 1, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 1, 0);
        add("t1", 0, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 1, 1);
        add("t1", 0, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 1, 2);
        add("t1", 0, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 1, 3);
        add("t1", 0, 4'b0001, 16'h0003, 4'b0000, 4'b0001, 0, 0);
        add("t1", 0, 4'b0000, 16'h0003, 4'b0000, 4'b0000, 0, 0);
        // Test 2: all requesting, all terms 0, each drops after its done.
        add("t2", 1, 4'b1111, 16'h0000, 4'b0001, 4'b0000, 1, 0);
        add("t2", 0, 4'b1111, 16'h0000, 4'b0000, 4'b0001, 0, 0);
        add("t2", 0, 4'b1110, 16'h0000, 4'b0010, 4'b0000, 1, 0);
        add("t2", 0, 4'b1110, 16'h0000, 4'b0000, 4'b0010, 0, 0);
        add("t2", 0, 4'b1100, 16'h0000, 4'b0100, 4'b0000, 1, 0);
        add("t2", 0, 4'b1100, 16'h0000, 4'b0000, 4'b0100, 0, 0);
        add("t2", 0, 4'b1000, 16'h0000, 4'b1000, 4'b0000, 1, 0);
        add("t2", 0, 4'b1000, 16'h0000, 4'b0000, 4'b1000, 0, 0);
        add("t2", 0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 0);
        // Test 3: req[2] held through done; done mask and RR pointer.
        add("t3", 1, 4'b1100, 16'h0000, 4'b0100, 4'b0000, 1, 0);
        add("t3", 0, 4'b1100, 16'h0000, 4'b0000, 4'b0100, 0, 0);
        add("t3", 0, 4'b1100, 16'h0000, 4'b1000, 4'b0000, 1, 0);
        add("t3", 0, 4'b1100, 16'h0000, 4'b0000, 4'b1000, 0, 0);
        add("t3", 0, 4'b0100, 16'h0000, 4'b0100, 4'b0000, 1, 0);
        add("t3", 0, 4'b0100, 16'h0000, 4'b0000, 4'b0100, 0, 0);
        add("t3", 0, 4'b0100, 16'h0000, 4'b0000, 4'b0000, 0, 0);
        add("t3", 0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 0);
        // Test 4: term1=15, req[1] dropped at count 5 -> abort.
        add("t4", 1, 4'b0010, 16'h00F0, 4'b0010, 4'b0000, 1, 0);
        for (int k = 1; k <= 5; k++)
            add("t4", 0, 4'b0010, 16'h00F0, 4'b0010, 4'b0000, 1, 4'(k));
        add("t4", 0, 4'b0000, 16'h00F0, 4'b0000, 4'b0000, 0, 0);
        add("t4", 0, 4'b0000, 16'h00F0, 4'b0000, 4'b0000, 0, 0);
        // Abort beats completion: term 0 and req dropped in the only RUN cycle.
        add("abort_vs_done", 1, 4'b0001, 16'h0000, 4'b0001, 4'b0000, 1, 0);
        add("abort_vs_done", 0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 0);
        // Test 5: term3=15, full count, no wrap; term change mid-run ignored.
        add("t5", 1, 4'b1000, 16'hF000, 4'b1000, 4'b0000, 1, 0);
        for (int k = 1; k <= 15; k++)
            add("t5", 0, 4'b1000, (k == 4) ? 16'h2000 : 16'hF000,
                4'b1000, 4'b0000, 1, 4'(k));
        add("t5", 0, 4'b1000, 16'hF000, 4'b0000, 4'b1000, 0, 0);
        add("t5", 0, 4'b0000, 16'hF000, 4'b0000, 4'b0000, 0, 0);

        reset = 1'b1;
        @(posedge clk);
        #1;
        check("power_on_reset", 4'b0000, 4'b0000, 1'b0, 4'd0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            req      = vecs[i].req;
            req_term = vecs[i].term;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", vecs[i].name, i), vecs[i].grant,
                  vecs[i].done, vecs[i].busy, vecs[i].count);
        end

        // Test 6: asynchronous reset at count 7, then requester 0 wins first.
        do_reset();
        req      = 4'b0100;
        req_term = 16'h0F00;
        repeat (8) @(posedge clk);
        #1;
        check("t6_count7", 4'b0100, 4'b0000, 1'b1, 4'd7);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_reset", 4'b0000, 4'b0000, 1'b0, 4'd0);
        req      = 4'b1111;
        req_term = 16'h0000;
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("t6_first_after_reset", 4'b0001, 4'b0000, 1'b1, 4'd0);
        req = 4'b0000;
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
